// File: rtl/rv_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | rv_ctrl_pkg : RV32I decoder opcodes, funct3 codes and ALU/WB enums |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package rv_ctrl_pkg;

  localparam logic [6:0] OP_R        = 7'b0110011;
  localparam logic [6:0] OP_I        = 7'b0010011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SR    = 3'b101;
  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [2:0] F3_FENCE = 3'b000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_t;

  // alt selects SUB/SRA; callers decide whether the alternate form is legal
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_br_cond.sv
// +--------------------------------------------------------------------+
// | rv_br_cond : branch taken / unsigned-compare select from funct3    |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module rv_br_cond
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_less,
  input  logic       br_equal,
  output logic       taken,
  output logic       br_un
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:            taken = br_equal;
      F3_BNE:            taken = ~br_equal;
      F3_BLT, F3_BLTU:   taken = br_less;
      F3_BGE, F3_BGEU:   taken = ~br_less;
      default:           taken = 1'b0;
    endcase
  end

  assign br_un = (funct3 == F3_BLTU) || (funct3 == F3_BGEU);

endmodule

`default_nettype wire

// File: rtl/rv_ctrl_unit.sv
// +--------------------------------------------------------------------+
// | rv_ctrl_unit : RV32I main decoder plus sticky illegal-instr capture|
// | Option       : CTRL_FENCE_EN decodes FENCE as a legal NOP          |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module rv_ctrl_unit
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_less,
  input  logic        br_equal,
  output logic        pc_sel,
  output logic        br_un,
  output logic        rd_wren,
  output logic        opa_sel,
  output logic        opb_sel,
  output logic [3:0]  alu_op,
  output logic        mem_wren,
  output logic [1:0]  wb_sel,
  output logic        insn_vld,
  output logic        ill_seen,
  output logic [31:0] ill_instr
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_br_taken;
  logic       w_br_un;

  logic       w_legal;
  logic       w_pc_sel;
  logic       w_un;
  logic       w_rd;
  logic       w_opa;
  logic       w_opb;
  logic       w_mem;
  alu_op_t    w_alu;
  wb_sel_t    w_wb;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  rv_br_cond u_br_cond (
    .funct3   (w_funct3),
    .br_less  (br_less),
    .br_equal (br_equal),
    .taken    (w_br_taken),
    .br_un    (w_br_un)
  );

  // Raw per-opcode controls; everything is masked by w_legal afterwards
  always_comb begin
    w_legal  = 1'b0;
    w_pc_sel = 1'b0;
    w_un     = 1'b0;
    w_rd     = 1'b0;
    w_opa    = 1'b0;
    w_opb    = 1'b0;
    w_mem    = 1'b0;
    w_alu    = ALU_ADD;
    w_wb     = WB_ALU;
    case (w_opcode)
      OP_R: begin
        w_rd    = 1'b1;
        w_alu   = alu_from_f3(w_funct3, w_funct7 == F7_ALT);
        w_legal = (w_funct7 == F7_BASE) ||
                  ((w_funct7 == F7_ALT) && ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR)));
      end
      OP_I: begin
        w_rd  = 1'b1;
        w_opb = 1'b1;
        w_alu = alu_from_f3(w_funct3, (w_funct3 == F3_SR) && (w_funct7 == F7_ALT));
        if (w_funct3 == F3_SLL)
          w_legal = (w_funct7 == F7_BASE);
        else if (w_funct3 == F3_SR)
          w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
        else
          w_legal = 1'b1;
      end
      OP_LOAD: begin
        w_rd    = 1'b1;
        w_opb   = 1'b1;
        w_wb    = WB_LOAD;
        w_legal = (w_funct3 == F3_LB) || (w_funct3 == F3_LH) || (w_funct3 == F3_LW) ||
                  (w_funct3 == F3_LBU) || (w_funct3 == F3_LHU);
      end
      OP_STORE: begin
        w_mem   = 1'b1;
        w_opb   = 1'b1;
        w_legal = (w_funct3 == F3_SB) || (w_funct3 == F3_SH) || (w_funct3 == F3_SW);
      end
      OP_BRANCH: begin
        w_opa    = 1'b1;
        w_opb    = 1'b1;
        w_pc_sel = w_br_taken;
        w_un     = w_br_un;
        w_legal  = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
      end
      OP_LUI: begin
        w_rd    = 1'b1;
        w_opb   = 1'b1;
        w_alu   = ALU_PASSB;
        w_legal = 1'b1;
      end
      OP_AUIPC: begin
        w_rd    = 1'b1;
        w_opa   = 1'b1;
        w_opb   = 1'b1;
        w_legal = 1'b1;
      end
      OP_JAL: begin
        w_pc_sel = 1'b1;
        w_rd     = 1'b1;
        w_opa    = 1'b1;
        w_opb    = 1'b1;
        w_wb     = WB_PC4;
        w_legal  = 1'b1;
      end
      OP_JALR: begin
        w_pc_sel = 1'b1;
        w_rd     = 1'b1;
        w_opb    = 1'b1;
        w_wb     = WB_PC4;
        w_legal  = (w_funct3 == F3_JALR);
      end
`ifdef CTRL_FENCE_EN
      OP_MISC_MEM: w_legal = (w_funct3 == F3_FENCE);
`else
      OP_MISC_MEM: w_legal = 1'b0;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  assign insn_vld = w_legal;
  assign pc_sel   = w_legal & w_pc_sel;
  assign br_un    = w_legal & w_un;
  assign rd_wren  = w_legal & w_rd;
  assign opa_sel  = w_legal & w_opa;
  assign opb_sel  = w_legal & w_opb;
  assign mem_wren = w_legal & w_mem;
  assign alu_op   = w_legal ? w_alu : ALU_ADD;
  assign wb_sel   = w_legal ? w_wb : WB_ALU;

  // Only the first illegal word after reset is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_seen  <= 1'b0;
      ill_instr <= 32'h0;
    end else if (!w_legal && !ill_seen) begin
      ill_seen  <= 1'b1;
      ill_instr <= instr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_ctrl_unit.sv
// +--------------------------------------------------------------------+
// | tb_rv_ctrl_unit : table-driven RV32I decode reference vs DUT       |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rv_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h002081B3;
  logic        br_less = 1'b0;
  logic        br_equal = 1'b0;
  logic        pc_sel, br_un, rd_wren, opa_sel, opb_sel, mem_wren, insn_vld, ill_seen;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;
  logic [31:0] ill_instr;

  int n_checks = 0;
  int n_fail   = 0;

  rv_ctrl_unit dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .br_less   (br_less),
    .br_equal  (br_equal),
    .pc_sel    (pc_sel),
    .br_un     (br_un),
    .rd_wren   (rd_wren),
    .opa_sel   (opa_sel),
    .opb_sel   (opb_sel),
    .alu_op    (alu_op),
    .mem_wren  (mem_wren),
    .wb_sel    (wb_sel),
    .insn_vld  (insn_vld),
    .ill_seen  (ill_seen),
    .ill_instr (ill_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_sel;
    logic       br_un;
    logic       rd_wren;
    logic       opa;
    logic       opb;
    logic [3:0] alu;
    logic       mem;
    logic [1:0] wb;
    logic       vld;
  } ctl_t;

  localparam int C_NO = 0, C_ALWAYS = 1, C_EQ = 2, C_NE = 3, C_LT = 4, C_GE = 5;

  // Instruction table in mask/match form as listed in the ISA manual
  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  ctl_t        t_ctl[$];
  int          t_cond[$];

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input logic rd,
                     input logic opa, input logic opb, input logic [3:0] alu, input logic mem,
                     input logic [1:0] wb, input int cond, input logic un);
    ctl_t c;
    c = '0;
    c.rd_wren = rd; c.opa = opa; c.opb = opb; c.alu = alu;
    c.mem = mem; c.wb = wb; c.br_un = un; c.vld = 1'b1;
    t_mask.push_back(mask); t_match.push_back(match);
    t_ctl.push_back(c); t_cond.push_back(cond);
  endtask

  task automatic build_table();
    logic [31:0] r, i, s, b, m;
    r = 32'hFE00707F; i = 32'h0000707F; m = 32'h0000007F; s = r; b = i;
    add(r, 32'h00000033, 1, 0, 0, 4'h0, 0, 0, C_NO, 0);
    add(r, 32'h40000033, 1, 0, 0, 4'h1, 0, 0, C_NO, 0);
    add(r, 32'h00001033, 1, 0, 0, 4'h2, 0, 0, C_NO, 0);
    add(r, 32'h00002033, 1, 0, 0, 4'h3, 0, 0, C_NO, 0);
    add(r, 32'h00003033, 1, 0, 0, 4'h4, 0, 0, C_NO, 0);
    add(r, 32'h00004033, 1, 0, 0, 4'h5, 0, 0, C_NO, 0);
    add(r, 32'h00005033, 1, 0, 0, 4'h6, 0, 0, C_NO, 0);
    add(r, 32'h40005033, 1, 0, 0, 4'h7, 0, 0, C_NO, 0);
    add(r, 32'h00006033, 1, 0, 0, 4'h8, 0, 0, C_NO, 0);
    add(r, 32'h00007033, 1, 0, 0, 4'h9, 0, 0, C_NO, 0);
    add(i, 32'h00000013, 1, 0, 1, 4'h0, 0, 0, C_NO, 0);
    add(i, 32'h00002013, 1, 0, 1, 4'h3, 0, 0, C_NO, 0);
    add(i, 32'h00003013, 1, 0, 1, 4'h4, 0, 0, C_NO, 0);
    add(i, 32'h00004013, 1, 0, 1, 4'h5, 0, 0, C_NO, 0);
    add(i, 32'h00006013, 1, 0, 1, 4'h8, 0, 0, C_NO, 0);
    add(i, 32'h00007013, 1, 0, 1, 4'h9, 0, 0, C_NO, 0);
    add(s, 32'h00001013, 1, 0, 1, 4'h2, 0, 0, C_NO, 0);
    add(s, 32'h00005013, 1, 0, 1, 4'h6, 0, 0, C_NO, 0);
    add(s, 32'h40005013, 1, 0, 1, 4'h7, 0, 0, C_NO, 0);
    add(i, 32'h00000003, 1, 0, 1, 4'h0, 0, 1, C_NO, 0);
    add(i, 32'h00001003, 1, 0, 1, 4'h0, 0, 1, C_NO, 0);
    add(i, 32'h00002003, 1, 0, 1, 4'h0, 0, 1, C_NO, 0);
    add(i, 32'h00004003, 1, 0, 1, 4'h0, 0, 1, C_NO, 0);
    add(i, 32'h00005003, 1, 0, 1, 4'h0, 0, 1, C_NO, 0);
    add(i, 32'h00000023, 0, 0, 1, 4'h0, 1, 0, C_NO, 0);
    add(i, 32'h00001023, 0, 0, 1, 4'h0, 1, 0, C_NO, 0);
    add(i, 32'h00002023, 0, 0, 1, 4'h0, 1, 0, C_NO, 0);
    add(b, 32'h00000063, 0, 1, 1, 4'h0, 0, 0, C_EQ, 0);
    add(b, 32'h00001063, 0, 1, 1, 4'h0, 0, 0, C_NE, 0);
    add(b, 32'h00004063, 0, 1, 1, 4'h0, 0, 0, C_LT, 0);
    add(b, 32'h00005063, 0, 1, 1, 4'h0, 0, 0, C_GE, 0);
    add(b, 32'h00006063, 0, 1, 1, 4'h0, 0, 0, C_LT, 1);
    add(b, 32'h00007063, 0, 1, 1, 4'h0, 0, 0, C_GE, 1);
    add(m, 32'h00000037, 1, 0, 1, 4'hA, 0, 0, C_NO, 0);
    add(m, 32'h00000017, 1, 1, 1, 4'h0, 0, 0, C_NO, 0);
    add(m, 32'h0000006F, 1, 1, 1, 4'h0, 0, 2, C_ALWAYS, 0);
    add(i, 32'h00000067, 1, 0, 1, 4'h0, 0, 2, C_ALWAYS, 0);
`ifdef CTRL_FENCE_EN
    add(i, 32'h0000000F, 0, 0, 0, 4'h0, 0, 0, C_NO, 0);
`endif
  endtask

  function automatic ctl_t model(input logic [31:0] w, input logic less, input logic eq);
    ctl_t c;
    c = '0;
    for (int k = 0; k < t_mask.size(); k++) begin
      if ((w & t_mask[k]) == t_match[k]) begin
        c = t_ctl[k];
        case (t_cond[k])
          C_ALWAYS: c.pc_sel = 1'b1;
          C_EQ:     c.pc_sel = eq;
          C_NE:     c.pc_sel = ~eq;
          C_LT:     c.pc_sel = less;
          C_GE:     c.pc_sel = ~less;
          default:  c.pc_sel = 1'b0;
        endcase
        return c;
      end
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: instr=%h got %h expected %h at %0t", name, instr, act, exp, $time);
    end
  endtask

  // Status-register model: first illegal word since reset
  logic        m_seen = 1'b0;
  logic [31:0] m_ill  = 32'h0;
  ctl_t        m_pos;

  always @(posedge rst) begin
    m_seen = 1'b0;
    m_ill  = 32'h0;
  end

  always @(posedge clk) begin
    if (!rst && !m_seen) begin
      m_pos = model(instr, br_less, br_equal);
      if (!m_pos.vld) begin
        m_seen = 1'b1;
        m_ill  = instr;
      end
    end
  end

  ctl_t e_neg, a_neg;
  always @(negedge clk) begin
    e_neg = model(instr, br_less, br_equal);
    a_neg = {pc_sel, br_un, rd_wren, opa_sel, opb_sel, alu_op, mem_wren, wb_sel, insn_vld};
    check("ctl_vector", 32'(a_neg), 32'(e_neg));
    check("ill_seen", {31'h0, ill_seen}, {31'h0, m_seen});
    check("ill_instr", ill_instr, m_ill);
  end

  task automatic drv(input logic [31:0] w, input logic less, input logic eq);
    @(posedge clk);
    #1;
    instr = w; br_less = less; br_equal = eq;
    #2;
  endtask

  function automatic logic [6:0] pick_op(input int idx);
    case (idx)
      0: return 7'h33;  1: return 7'h13;  2: return 7'h03;  3: return 7'h23;
      4: return 7'h63;  5: return 7'h37;  6: return 7'h17;  7: return 7'h6F;
      8: return 7'h67;  9: return 7'h0F;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    build_table();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ill_seen", {31'h0, ill_seen}, 32'h0);
    check("rst_ill_instr", ill_instr, 32'h0);
    rst = 1'b0;

    drv(32'h002081B3, 0, 0);
    check("add_rd", {31'h0, rd_wren}, 1); check("add_opa", {31'h0, opa_sel}, 0);
    check("add_opb", {31'h0, opb_sel}, 0); check("add_alu", {28'h0, alu_op}, 0);
    check("add_wb", {30'h0, wb_sel}, 0);  check("add_vld", {31'h0, insn_vld}, 1);
    drv(32'h402081B3, 0, 0);
    check("sub_alu", {28'h0, alu_op}, 1);
    drv(32'h0000A103, 0, 0);
    check("lw_rd", {31'h0, rd_wren}, 1); check("lw_opb", {31'h0, opb_sel}, 1);
    check("lw_alu", {28'h0, alu_op}, 0); check("lw_wb", {30'h0, wb_sel}, 1);
    check("lw_mem", {31'h0, mem_wren}, 0);
    drv(32'h0020A023, 0, 0);
    check("sw_mem", {31'h0, mem_wren}, 1); check("sw_rd", {31'h0, rd_wren}, 0);
    check("sw_opb", {31'h0, opb_sel}, 1);
    drv(32'h00208063, 0, 1);
    check("beq_pc", {31'h0, pc_sel}, 1); check("beq_opa", {31'h0, opa_sel}, 1);
    check("beq_opb", {31'h0, opb_sel}, 1); check("beq_rd", {31'h0, rd_wren}, 0);
    drv(32'h00209063, 0, 1);
    check("bne_pc", {31'h0, pc_sel}, 0);
    drv(32'h0020E063, 1, 0);
    check("bltu_un", {31'h0, br_un}, 1); check("bltu_pc", {31'h0, pc_sel}, 1);
    drv(32'h000011B7, 0, 0);
    check("lui_alu", {28'h0, alu_op}, 32'hA); check("lui_opb", {31'h0, opb_sel}, 1);
    check("lui_wb", {30'h0, wb_sel}, 0);
    drv(32'h000011EF, 0, 0);
    check("jal_pc", {31'h0, pc_sel}, 1); check("jal_opa", {31'h0, opa_sel}, 1);
    check("jal_wb", {30'h0, wb_sel}, 2); check("jal_rd", {31'h0, rd_wren}, 1);
    drv(32'h00008167, 0, 0);
    check("jalr_pc", {31'h0, pc_sel}, 1); check("jalr_opa", {31'h0, opa_sel}, 0);
    check("jalr_wb", {30'h0, wb_sel}, 2);

    drv(32'hFFFFFFFF, 1, 1);
    check("ill1_vld", {31'h0, insn_vld}, 0); check("ill1_rd", {31'h0, rd_wren}, 0);
    check("ill1_mem", {31'h0, mem_wren}, 0); check("ill1_seen_pre", {31'h0, ill_seen}, 0);
    drv(32'h00000000, 0, 0);
    check("ill2_vld", {31'h0, insn_vld}, 0); check("ill2_rd", {31'h0, rd_wren}, 0);
    check("ill2_mem", {31'h0, mem_wren}, 0);
    check("cap_seen", {31'h0, ill_seen}, 1); check("cap_instr", ill_instr, 32'hFFFFFFFF);
    drv(32'h002081B3, 0, 0);
    check("hold_seen", {31'h0, ill_seen}, 1); check("hold_instr", ill_instr, 32'hFFFFFFFF);
    #1 rst = 1'b1;
    #1;
    check("arst_seen", {31'h0, ill_seen}, 0); check("arst_instr", ill_instr, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int n = 0; n < 800; n++) begin
      ra = $urandom; rb = $urandom;
      op = pick_op($urandom_range(0, 11));
      f3 = ra[2:0];
      case (ra[4:3])
        2'd0, 2'd1: f7 = 7'h00;
        2'd2:       f7 = 7'h20;
        default:    f7 = ra[11:5];
      endcase
      drv({f7, rb[24:15], f3, rb[11:7], op}, ra[12], ra[13]);
      if (n % 150 == 149) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rv_ctrl_unit.md
Name: rv_ctrl_unit

Overview:
- Main decoder for the RV32I single-cycle core. Maps the current 32-bit instruction and the branch comparator flags to datapath controls: PC select, regfile write, ALU operand/op select, store enable and writeback select.
- All datapath controls are combinational, so they are valid in the same cycle as `instr`.
- A small clocked status block latches the first illegal instruction seen, for debug and trap hooks.

Parameters:
- None. Widths are fixed by RV32I.

Ports:
- clk  in  1  core clock; samples the status registers only.
- rst  in  1  asynchronous active-high reset.
- instr  in  32  instruction currently being executed.
- br_less  in  1  rs1 < rs2 (signedness set by br_un).
- br_equal  in  1  rs1 == rs2.
- pc_sel  out  1  0 = PC+4; 1 = ALU result (jump/branch target).
- br_un  out  1  1 = unsigned compare.
- rd_wren  out  1  register file write enable.
- opa_sel  out  1  0 = rs1; 1 = PC.
- opb_sel  out  1  0 = rs2; 1 = immediate.
- alu_op  out  4  ALU operation code (see encoding in Behaviour).
- mem_wren  out  1  store enable.
- wb_sel  out  2  00 = ALU; 01 = load data; 10 = PC+4; 11 = reserved, never driven.
- insn_vld  out  1  1 = legal decoded instruction.
- ill_seen  out  1  sticky flag: an illegal instruction has been seen since reset.
- ill_instr  out  32  first illegal instruction captured.

Behaviour:
- alu_op encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010. Other codes are unused.
- instr[1:0] != 2'b11 is illegal.
- R-type (0110011):
  - rd_wren=1, opa=0, opb=0, wb=00, alu_op from funct3/funct7.
  - funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - Any other funct7 != 0000000 is illegal.
- I-ALU (0010011): rd_wren=1, opa=0, opb=1, wb=00.
  - SLLI requires funct7=0000000.
  - SRLI/SRAI require funct7 = 0000000 or 0100000 respectively.
  - No SUBI: funct3=000 is always ADD.
- LOAD (0000011): rd_wren=1, opb=1, alu ADD, wb=01. funct3 in {000,001,010,100,101}; anything else is illegal.
- STORE (0100011): mem_wren=1, rd_wren=0, opb=1, alu ADD. funct3 in {000,001,010}.
- BRANCH (1100011): opa=1, opb=1, alu ADD, rd_wren=0.
  - br_un=1 for funct3 110/111.
  - pc_sel=1 when taken: BEQ equal; BNE !equal; BLT/BLTU less; BGE/BGEU !less.
  - funct3 010/011 is illegal.
- LUI (0110111): rd_wren=1, opb=1, alu PASSB, wb=00.
- AUIPC (0010111): rd_wren=1, opa=1, opb=1, alu ADD, wb=00.
- JAL (1101111): pc_sel=1, rd_wren=1, opa=1, opb=1, alu ADD, wb=10.
- JALR (1100111): pc_sel=1, rd_wren=1, opa=0, opb=1, alu ADD, wb=10. funct3 must be 000.
- Defaults: every output not listed for an opcode is 0; br_un=0 except for unsigned branches.
- Illegal instruction:
  - insn_vld=0, pc_sel=0, rd_wren=0, mem_wren=0; all other controls 0.
  - The core simply advances PC with no architectural side effect.
- Status registers:
  - On a rising clk edge with insn_vld=0 and ill_seen=0: ill_seen<=1, ill_instr<=instr.
  - Later illegal instructions do not overwrite the capture.
- Reset: rst=1 asynchronously forces ill_seen=0 and ill_instr=0. Combinational outputs are unaffected by rst and remain a pure function of the inputs.

Optional Feature:
- CTRL_FENCE_EN defined: MISC-MEM (0001111) with funct3=000 (FENCE) decodes as a legal NOP: insn_vld=1, all enables 0.
- Not defined: opcode 0001111 is illegal.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode localparams;
  - the alu_op enum and wb_sel enum;
  - funct3 constants for branch, load and store.
- One natural sub-module, rv_br_cond: funct3 + br_less + br_equal -> taken, br_un. The top-level decode plus status registers stay in rv_ctrl_unit.

Test Plan:
- ADD 0x002081B3 -> rd_wren=1, opa=0, opb=0, alu=0000, wb=00, vld=1. SUB 0x402081B3 -> alu=0001.
- LW 0x0000A103 -> rd_wren=1, opb=1, alu=0000, wb=01, mem_wren=0. SW 0x0020A023 -> mem_wren=1, rd_wren=0, opb=1.
- BEQ 0x00208063 with equal=1 -> pc_sel=1, opa=1, opb=1, rd_wren=0.
- BNE 0x00209063 with equal=1 -> pc_sel=0.
- BLTU (funct3=110) with less=1 -> br_un=1, pc_sel=1.
- LUI 0x000011B7 -> alu=1010, opb=1, wb=00.
- JAL 0x000011EF -> pc_sel=1, opa=1, wb=10, rd_wren=1.
- JALR 0x00008167 -> pc_sel=1, opa=0, wb=10.
- Illegal 0xFFFFFFFF, then 0x00000000, then ADD:
  - vld=0, rd_wren=0, mem_wren=0 for both illegal words;
  - after the first clk edge, ill_seen=1 and ill_instr=0xFFFFFFFF, unchanged thereafter;
  - asserting rst mid-cycle clears both asynchronously.
